// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared channel state type, default parameters and width helpers.
package sw_debounce_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chState_t;

  localparam int unsigned DEF_N          = 4;
  localparam int unsigned DEF_TICK_DIV   = 50000;
  localparam int unsigned DEF_STABLE_CNT = 8;
  localparam bit          DEF_RST_LVL    = 1'b0;
  localparam int unsigned DEF_REPEAT_DLY = 100;
  localparam int unsigned DEF_REPEAT_PER = 20;

  // Bits needed to hold 0..maxVal (at least one bit)
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  // Bits needed for a prescaler counting 0..div-1 (at least one bit)
  function automatic int unsigned preWidth(input int unsigned div);
    return (div < 3) ? 1 : $clog2(div);
  endfunction

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one debounce channel (2-FF sync, tick-sampled stability FSM,
// registered level and edge pulses, optional auto-repeat when
// SW_DEBOUNCE_AUTOREPEAT_EN is defined).
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter bit          RST_LVL    = DEF_RST_LVL
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
`endif
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic tick,
  input  logic sw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int unsigned       CNT_W    = cntWidth(STABLE_CNT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT);

  logic [1:0]       syncQ;
  logic             s;
  chState_t         state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             commit;
  logic             lvlNxt, riseNxt, fallNxt;

  assign s = syncQ[1];

  // State register: synchronizer, FSM, counter and registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      syncQ <= {2{RST_LVL}};
      state <= ST_STABLE;
      cnt   <= '0;
      lvl   <= RST_LVL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], sw};
      state <= stateNxt;
      cnt   <= cntNxt;
      lvl   <= lvlNxt;
      rise  <= riseNxt;
      fall  <= fallNxt;
    end
  end

  // Next state: only tick cycles move the FSM; a mismatch must persist STABLE_CNT ticks
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    commit   = 1'b0;
    if (tick) begin
      case (state)
        ST_STABLE: begin
          if (s == lvl) begin
            cntNxt = '0;
          end else if (STABLE_CNT == 1) begin
            commit = 1'b1;
            cntNxt = '0;
          end else begin
            stateNxt = ST_PENDING;
            cntNxt   = CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (s == lvl) begin
            stateNxt = ST_STABLE;
            cntNxt   = '0;
          end else if ((cnt + CNT_W'(1)) == CNT_LAST) begin
            commit   = 1'b1;
            stateNxt = ST_STABLE;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          stateNxt = ST_STABLE;
          cntNxt   = '0;
        end
      endcase
    end
  end

`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned        HOLD_W  = cntWidth(maxU(REPEAT_DLY, REPEAT_PER));
  localparam logic [HOLD_W-1:0]  DLY_VAL = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0]  PER_VAL = HOLD_W'(REPEAT_PER);

  logic [HOLD_W-1:0] holdCnt, holdNxt;
  logic              rptPhase, rptPhaseNxt;
  logic              rptFire;

  // Hold counter register: ticks since the last press commit or repeat
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      holdCnt  <= '0;
      rptPhase <= 1'b0;
    end else begin
      holdCnt  <= holdNxt;
      rptPhase <= rptPhaseNxt;
    end
  end

  // Repeat timing: first repeat after REPEAT_DLY held ticks, then every REPEAT_PER
  always_comb begin
    holdNxt     = holdCnt;
    rptPhaseNxt = rptPhase;
    rptFire     = 1'b0;
    if (commit || !lvl) begin
      holdNxt     = '0;
      rptPhaseNxt = 1'b0;
    end else if (tick) begin
      if ((holdCnt + HOLD_W'(1)) == (rptPhase ? PER_VAL : DLY_VAL)) begin
        rptFire     = 1'b1;
        holdNxt     = '0;
        rptPhaseNxt = 1'b1;
      end else begin
        holdNxt = holdCnt + HOLD_W'(1);
      end
    end
  end
`endif

  // Output values: commit updates the level and emits one edge pulse
  always_comb begin
    lvlNxt  = lvl;
    riseNxt = 1'b0;
    fallNxt = 1'b0;
    if (commit) begin
      lvlNxt  = s;
      riseNxt = s;
      fallNxt = ~s;
    end
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    else if (rptFire) begin
      riseNxt = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N-channel switch/button debouncer sharing one sample-tick prescaler.
// Optional auto-repeat of oRISE on held inputs: define SW_DEBOUNCE_AUTOREPEAT_EN.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter bit          RST_LVL    = DEF_RST_LVL,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [N-1:0] iSW,
  output logic [N-1:0] oLVL,
  output logic [N-1:0] oRISE,
  output logic [N-1:0] oFALL,
  output logic         oTICK
);

  localparam int unsigned       PRE_W    = preWidth(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] preCnt, preNxt;

  // Prescaler next count: 0..TICK_DIV-1 then wrap
  always_comb begin
    preNxt = preCnt + PRE_W'(1);
    if (preCnt == PRE_LAST) begin
      preNxt = '0;
    end
  end

  // Prescaler and registered tick, high exactly while the count equals TICK_DIV-1
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      preCnt <= '0;
      oTICK  <= 1'b0;
    end else begin
      preCnt <= preNxt;
      oTICK  <= (preNxt == PRE_LAST);
    end
  end

  // Reject configurations the channel arithmetic cannot support
  if (TICK_DIV < 2 || STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : gBadCfg
    $error("sw_debounce: TICK_DIV must be >=2 and STABLE_CNT/REPEAT_DLY/REPEAT_PER >=1");
  end

  for (genvar gi = 0; gi < int'(N); gi++) begin : gCh
    sw_debounce_ch #(
      .STABLE_CNT(STABLE_CNT),
      .RST_LVL   (RST_LVL)
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
`endif
    ) uCh (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .tick  (oTICK),
      .sw    (iSW[gi]),
      .lvl   (oLVL[gi]),
      .rise  (oRISE[gi]),
      .fall  (oFALL[gi])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: self-checking bench for sw_debounce (N=4, TICK_DIV=4, STABLE_CNT=3).
module tb_sw_debounce;

  localparam int N          = 4;
  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;
  localparam int REPEAT_DLY = 5;
  localparam int REPEAT_PER = 2;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [3:0] iSW;
  logic [3:0] oLVL, oRISE, oFALL;
  logic       oTICK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] mLvl, mRise, mFall;
  logic       mTick;
  int         mCyc;
  logic [3:0] swQ[$];
  int         run[4];
  int         held[4];

  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic [3:0] expLvl;
  } vec_t;
  vec_t vecs[7];

  sw_debounce #(
    .N(N), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT), .RST_LVL(1'b0),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSW(iSW),
    .oLVL(oLVL), .oRISE(oRISE), .oFALL(oFALL), .oTICK(oTICK)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mCyc  = 0;
    swQ.delete();
    mLvl  = 4'b0000;
    mRise = 4'b0000;
    mFall = 4'b0000;
    mTick = 1'b0;
    for (int c = 0; c < N; c++) begin
      run[c]  = 0;
      held[c] = 0;
    end
  endtask

  // Advance the model over one clock edge: sampled value = input two edges old;
  // a level changes once STABLE_CNT consecutive ticks all disagree with it.
  task automatic modelEdge();
    logic [3:0] s;
    logic [1:0] ci;
    bit         tk;
    if (!iRST_N) begin
      modelReset();
      return;
    end
    s     = (swQ.size() >= 2) ? swQ[swQ.size() - 2] : 4'b0000;
    tk    = (mCyc % TICK_DIV) == (TICK_DIV - 1);
    mRise = 4'b0000;
    mFall = 4'b0000;
    if (tk) begin
      for (int c = 0; c < N; c++) begin
        ci = 2'(c);
        if (s[ci] != mLvl[ci]) run[c]++;
        else run[c] = 0;
        if (run[c] == STABLE_CNT) begin
          mLvl[ci] = s[ci];
          if (s[ci]) mRise[ci] = 1'b1;
          else mFall[ci] = 1'b1;
          run[c]  = 0;
          held[c] = 0;
        end else if (mLvl[ci]) begin
          held[c]++;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
          if (held[c] == REPEAT_DLY ||
              (held[c] > REPEAT_DLY && ((held[c] - REPEAT_DLY) % REPEAT_PER) == 0))
            mRise[ci] = 1'b1;
`endif
        end
      end
    end
    swQ.push_back(iSW);
    if (swQ.size() > 2) void'(swQ.pop_front());
    mCyc++;
    mTick = (mCyc % TICK_DIV) == (TICK_DIV - 1);
  endtask

  task automatic step();
    @(posedge iCLK);
    modelEdge();
    #1;
    check("lvl", 32'(oLVL), 32'(mLvl));
    check("rise", 32'(oRISE), 32'(mRise));
    check("fall", 32'(oFALL), 32'(mFall));
    check("tick", 32'(oTICK), 32'(mTick));
    check("rise_fall_excl", 32'(oRISE & oFALL), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat, nPulse, seen, rptQ[$], expRpt[$];

    vecs[0] = '{4'b0001, 20, 4'b0001};
    vecs[1] = '{4'b0011,  6, 4'b0001};
    vecs[2] = '{4'b0001, 20, 4'b0001};
    vecs[3] = '{4'b0000, 20, 4'b0000};
    vecs[4] = '{4'b0110, 20, 4'b0110};
    vecs[5] = '{4'b0100, 20, 4'b0100};
    vecs[6] = '{4'b0000, 20, 4'b0000};

    // Reset state
    iSW    = 4'b0000;
    iRST_N = 1'b0;
    modelReset();
    steps(3);
    check("rst_lvl", 32'(oLVL), 32'd0);
    check("rst_rise", 32'(oRISE), 32'd0);
    check("rst_fall", 32'(oFALL), 32'd0);
    check("rst_tick", 32'(oTICK), 32'd0);
    iRST_N = 1'b1;
    steps(5);

    // Clean press on channel 0
    iSW = 4'b0001; lat = 0; nPulse = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (oRISE[0]) nPulse++;
      if (lat == 0 && oLVL[0]) begin
        lat = e;
        check("press_rise_with_lvl", 32'(oRISE), 32'h1);
      end
    end
    check("press_latency_le15", 32'(lat >= 1 && lat <= 15), 32'd1);
    check("press_rise_count", 32'(nPulse), 32'd1);
    check("press_lvl", 32'(oLVL), 32'h1);

    // Release on channel 0
    iSW = 4'b0000; lat = 0; nPulse = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (oFALL[0]) nPulse++;
      if (lat == 0 && !oLVL[0]) begin
        lat = e;
        check("release_fall_with_lvl", 32'(oFALL), 32'h1);
      end
    end
    check("release_latency_le15", 32'(lat >= 1 && lat <= 15), 32'd1);
    check("release_fall_count", 32'(nPulse), 32'd1);

    // Simultaneous commit on channels 1 and 3
    iSW = 4'b1010; seen = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (seen == 0 && oLVL != 4'b0000) begin
        seen = 1;
        check("simul_lvl", 32'(oLVL), 32'hA);
        check("simul_rise", 32'(oRISE), 32'hA);
      end
    end
    check("simul_seen", 32'(seen), 32'd1);
    iSW = 4'b0000;
    steps(20);

    // Table vectors: press, glitch, hold, release, multi-bit changes
    for (int v = 0; v < 7; v++) begin
      iSW = vecs[v].sw;
      steps(vecs[v].hold);
      check($sformatf("vec%0d_lvl", v), 32'(oLVL), 32'(vecs[v].expLvl));
    end

    // Reset in the middle of a pending change on channel 2
    iSW = 4'b0100;
    steps(2);
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      step();
      if (oTICK) seen = 1;
    end
    check("pend_tick_seen", 32'(seen), 32'd1);
    step();
    iRST_N = 1'b0;
    modelReset();
    #1;
    check("async_rst_lvl", 32'(oLVL), 32'd0);
    check("async_rst_rise", 32'(oRISE), 32'd0);
    check("async_rst_tick", 32'(oTICK), 32'd0);
    steps(3);
    iRST_N = 1'b1;
    nPulse = 0;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (oRISE != 4'b0000) nPulse++;
    end
    check("post_rst_no_pulse", 32'(nPulse), 32'd0);
    check("post_rst_lvl_e11", 32'(oLVL), 32'd0);
    step();
    check("post_rst_lvl_e12", 32'(oLVL), 32'h4);
    check("post_rst_rise_e12", 32'(oRISE), 32'h4);

    // Randomized stimulus against the model
    for (int r = 0; r < 40; r++) begin
      iSW = 4'($urandom);
      steps(int'($urandom_range(1, 20)));
    end

    // Held press on channel 3: pulse positions after reset release
    iRST_N = 1'b0;
    modelReset();
    iSW = 4'b1000;
    steps(2);
    iRST_N = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (oRISE[3]) rptQ.push_back(e);
    end
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    expRpt = '{12, 32, 40, 48, 56};
`else
    expRpt = '{12};
`endif
    check("hold_pulse_count", 32'(rptQ.size()), 32'(expRpt.size()));
    for (int i = 0; i < expRpt.size() && i < rptQ.size(); i++)
      check($sformatf("hold_pulse%0d_edge", i), 32'(rptQ[i]), 32'(expRpt[i]));
    check("hold_lvl", 32'(oLVL), 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side companion to the LED pattern drivers: it turns raw board switches and buttons into clean control signals.
- Each channel gets a 2-FF synchronizer, tick-based debouncing, a debounced level, and one-cycle rise/fall pulses.
- The outputs feed direction/step controls of display blocks directly; no clock-enable tricks and no derived clocks (a single iCLK domain).

Parameters:
- N, 4, number of independent switch/button channels
- TICK_DIV, 50000, iCLK cycles per sample tick (>=2)
- STABLE_CNT, 8, consecutive ticks of the new level required to commit (>=1)
- RST_LVL, 0, debounced level each channel takes in reset (applied to all bits)
- REPEAT_DLY, 100, ticks held high before the first auto-repeat (AUTOREPEAT_EN only)
- REPEAT_PER, 20, ticks between subsequent auto-repeats (AUTOREPEAT_EN only)

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  reset, asynchronous, active-low
- iSW  in  N  raw asynchronous switch/button levels
- oLVL  out  N  debounced level
- oRISE  out  N  one-iCLK pulse on committed 0->1 (plus repeats if enabled)
- oFALL  out  N  one-iCLK pulse on committed 1->0
- oTICK  out  1  one-iCLK sample strobe, exported for bench and neighbours

Behaviour:
- Reset, asynchronous, while iRST_N=0:
  - oLVL = all RST_LVL; oRISE = oFALL = 0; oTICK = 0.
  - Prescaler = 0; synchronizer FFs = RST_LVL; all channels in STABLE with cnt = 0.
- Release: iRST_N is synchronized in by the integrator. The block starts counting on the first iCLK edge after deassertion.
- Prescaler:
  - Counter of width $clog2(TICK_DIV) counts 0..TICK_DIV-1, then wraps to 0.
  - oTICK = 1 for exactly the cycle in which the counter equals TICK_DIV-1.
- Synchronizer: s[i] is iSW[i] delayed 2 iCLK. Channels act only on s, never on raw iSW.
- Per-channel FSM, evaluated only on cycles with oTICK = 1:
  - STABLE (level L):
    - s == L: stay, cnt = 0.
    - s != L and STABLE_CNT == 1: commit immediately.
    - s != L otherwise: go to PENDING, cnt = 1.
  - PENDING:
    - s == L: back to STABLE, cnt = 0. The glitch is rejected and produces no output.
    - s != L and cnt+1 == STABLE_CNT: commit.
    - s != L otherwise: cnt++.
  - Commit: on the iCLK edge ending the tick cycle, L <= s and oLVL[i] <= s. In the same registered cycle, oRISE[i] = 1 if s = 1, or oFALL[i] = 1 if s = 0. The pulse lasts exactly 1 cycle.
- Latency, input edge to oLVL change: 2 sync cycles + wait to next tick + (STABLE_CNT-1) × TICK_DIV cycles + 1 register.
- Channels are fully independent. Simultaneous commits on several channels in one tick are allowed, and several oRISE/oFALL bits can be set in the same cycle.
- The cnt counter is $clog2(STABLE_CNT+1) bits wide and cannot overflow (bounded by STABLE_CNT).
- Reset mid-PENDING: the pending change is discarded, no pulse is emitted, and oLVL returns to RST_LVL.
- oRISE and oFALL are never both 1 on the same bit.

Optional Feature:
- Macro: SW_DEBOUNCE_AUTOREPEAT_EN
- Defined:
  - While oLVL[i] = 1, a per-channel hold counter counts ticks.
  - After REPEAT_DLY ticks, oRISE[i] pulses again, then every REPEAT_PER ticks after that.
  - The hold counter clears on fall and on reset.
  - oLVL is unaffected.
- Undefined: no hold counter logic exists, and oRISE pulses exactly once per committed press.

Decomposition:
- Package sw_debounce_pkg:
  - Channel state enum {ST_STABLE, ST_PENDING}.
  - Width helper constants derived from TICK_DIV, STABLE_CNT and REPEAT_DLY.
- Sub-module sw_debounce_ch: one channel holding sync, FSM, cnt and optional repeat logic.
- The top holds the shared prescaler and a generate loop over N instances.

Test Plan (bench uses N=4, TICK_DIV=4, STABLE_CNT=3, RST_LVL=0, REPEAT_DLY=5, REPEAT_PER=2):
- Clean press: iSW[0] 0->1 held → oLVL[0] = 1 within 2+4+8+1 = 15 cycles; oRISE[0] high for exactly 1 cycle; other bits stay 0.
- Glitch: iSW[1] high for 6 cycles (spans ≤2 ticks), then low → oLVL[1] stays 0; no oRISE/oFALL ever.
- Release: after the press commits, iSW[0] 1->0 held → oFALL[0] is a single-cycle pulse; oLVL[0] = 0 after the same latency bound.
- Simultaneous: iSW = 4'b1010 in one cycle → oLVL = 4'b1010 and oRISE = 4'b1010 pulse in the same cycle.
- Reset mid-pending: iSW[2] high for 1 tick, then iRST_N = 0 for 3 cycles → all outputs 0 immediately (asynchronously); no pulse after release while iSW[2] remains high, until a full 3-tick commit occurs anew.
- Autorepeat (macro defined): hold iSW[3] high → oRISE[3] pulses at commit, again 5 ticks later, then every 2 ticks; undefined build → exactly one pulse.
